// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM with bit-centre timing, frame assembly and host status flags
`timescale 1ns/1ps
module uart_rx_ctrl #(
   parameter int KW = 19
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          RX,
   input  logic [KW-1:0] K,
   input  logic          EIGHT,
   input  logic          PEN,
   input  logic          OHEL,
   input  logic          CLR_RDY,
   output logic [7:0]    RX_DATA,
   output logic          RXRDY,
   output logic          PERR,
   output logic          FERR,
   output logic          OVF
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
   state_t state, nxt;
   logic [KW-1:0] cnt, target;
   logic [3:0] bits, n;
   logic [8:0] sr, val;
   logic [1:0] sh;
   logic [7:0] data;
   logic e, p, o, stop_bit, strobe, par;
   always_comb begin
      target = (state == START) ? (K >> 1) : K;
      strobe = cnt == target - KW'(1);
      n = 4'd8 + {3'd0, e} + {3'd0, p};
      // shift register fills from the top; realign so the first data bit lands at bit 0
      sh = 2'd2 - {1'b0, e} - {1'b0, p};
      val = sr >> sh;
      data = {e & val[7], val[6:0]};
      par = e ? val[8] : val[7];
      nxt = state;
      unique case (state)
         IDLE:    nxt = RX ? IDLE : START;
         START:   nxt = strobe ? (RX ? IDLE : DATA) : START;
         DATA:    nxt = (strobe && bits + 4'd1 == n) ? STOP : DATA;
         STOP:    nxt = strobe ? DONE : STOP;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (RESET) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt <= '0;
         bits <= '0;
         sr <= '0;
         {e, p, o, stop_bit} <= '0;
         RX_DATA <= '0;
         {RXRDY, PERR, FERR, OVF} <= '0;
      end else begin
         cnt <= (state == IDLE || state != nxt || strobe) ? '0 : cnt + KW'(1);
         if (state == IDLE && !RX) begin
            {e, p, o} <= {EIGHT, PEN, OHEL};
            bits <= '0;
         end
         if (state == START && strobe) bits <= 4'd1;
         if (state == DATA && strobe) begin
            sr <= {RX, sr[8:1]};
            bits <= bits + 4'd1;
         end
         if (state == STOP && strobe) stop_bit <= RX;
         if (state == DONE) begin
            RX_DATA <= data;
            PERR <= p & (^data ^ par ^ o);
            FERR <= ~stop_bit;
            RXRDY <= 1'b1;
            OVF <= RXRDY & ~CLR_RDY;
         end else if (CLR_RDY) begin
            RXRDY <= 1'b0;
            OVF <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame tests for the UART receive controller
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
   logic        CLK = 0, RESET = 1, RX = 1, EIGHT = 1, PEN = 0, OHEL = 0, CLR_RDY = 0;
   logic [18:0] K = 19'd8;
   logic [7:0]  RX_DATA;
   logic        RXRDY, PERR, FERR, OVF;
   int tests = 0, fails = 0, lat;

   uart_rx_ctrl #(.KW(19)) dut (
      .CLK(CLK), .RESET(RESET), .RX(RX), .K(K), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
      .CLR_RDY(CLR_RDY), .RX_DATA(RX_DATA), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   // v holds data then parity, LSB first; lat = posedges from start-edge sample to RXRDY high
   task automatic send(input logic [8:0] v, input int nb, input int k, input logic stop,
                       input int clr_at, input int tog_at, output int l);
      int cyc = -1;
      l = -1;
      for (int b = 0; b < nb + 2; b++) begin
         RX = (b == 0) ? 1'b0 : (b == nb + 1) ? stop : v[b-1];
         for (int j = 0; j < k; j++) begin
            @(posedge CLK); cyc++;
            @(negedge CLK);
            CLR_RDY = (cyc == clr_at);
            if (cyc == tog_at) EIGHT = ~EIGHT;
            if (RXRDY && l < 0) l = cyc;
         end
      end
      RX = 1'b1;
      CLR_RDY = 1'b0;
      repeat (2 * k) @(negedge CLK);
   endtask

   task automatic pulse_clr;
      CLR_RDY = 1'b1;
      @(negedge CLK);
      CLR_RDY = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge CLK);
      RESET = 0;
      @(negedge CLK);
      tests++; if (RX_DATA !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {RXRDY, PERR, FERR, OVF}); end
   endtask

   task automatic test_8n1;
      K = 8; EIGHT = 1; PEN = 0;
      send(9'h0A5, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (lat !== 77) begin fails++; $display("FAIL 8n1_lat got %0d exp 77", lat); end
      tests++; if (RX_DATA !== 8'hA5) begin fails++; $display("FAIL 8n1_data got %h exp a5", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1000) begin fails++; $display("FAIL 8n1_flags got %b exp 1000", {RXRDY, PERR, FERR, OVF}); end
      pulse_clr;
      tests++; if ({RXRDY, OVF} !== 2'b00) begin fails++; $display("FAIL 8n1_clr got %b exp 00", {RXRDY, OVF}); end
   endtask

   task automatic test_7e;
      EIGHT = 0; PEN = 1; OHEL = 0;
      send(9'h055, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (lat !== 77) begin fails++; $display("FAIL 7e_lat got %0d exp 77", lat); end
      tests++; if (RX_DATA !== 8'h55) begin fails++; $display("FAIL 7e_data got %h exp 55", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1000) begin fails++; $display("FAIL 7e_flags got %b exp 1000", {RXRDY, PERR, FERR, OVF}); end
      pulse_clr;
      send(9'h0D5, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (RX_DATA !== 8'h55) begin fails++; $display("FAIL 7e_bad_data got %h exp 55", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1100) begin fails++; $display("FAIL 7e_bad_flags got %b exp 1100", {RXRDY, PERR, FERR, OVF}); end
      pulse_clr;
   endtask

   task automatic test_odd_ferr;
      K = 10; EIGHT = 1; PEN = 1; OHEL = 1;
      send(9'h1FF, 9, 10, 1'b0, -1, -1, lat);
      tests++; if (lat !== 106) begin fails++; $display("FAIL odd_lat got %0d exp 106", lat); end
      tests++; if (RX_DATA !== 8'hFF) begin fails++; $display("FAIL odd_data got %h exp ff", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1010) begin fails++; $display("FAIL odd_flags got %b exp 1010", {RXRDY, PERR, FERR, OVF}); end
      pulse_clr;
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b0010) begin fails++; $display("FAIL odd_hold got %b exp 0010", {RXRDY, PERR, FERR, OVF}); end
      K = 8; PEN = 0; OHEL = 0;
   endtask

   task automatic test_glitch;
      logic seen = 0;
      RX = 0;
      repeat (2) @(negedge CLK);
      RX = 1;
      repeat (4) begin @(negedge CLK); if (RXRDY) seen = 1; end
      send(9'h03C, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL glitch_rdy got %b exp 0", seen); end
      tests++; if (lat !== 77) begin fails++; $display("FAIL glitch_lat got %0d exp 77", lat); end
      tests++; if (RX_DATA !== 8'h3C) begin fails++; $display("FAIL glitch_data got %h exp 3c", RX_DATA); end
   endtask

   task automatic test_overrun;
      pulse_clr;
      send(9'h012, 8, 8, 1'b1, -1, -1, lat);
      tests++; if ({RX_DATA, RXRDY, OVF} !== {8'h12, 2'b10}) begin fails++; $display("FAIL ovr_first got %h/%b exp 12/10", RX_DATA, {RXRDY, OVF}); end
      send(9'h034, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (RX_DATA !== 8'h34) begin fails++; $display("FAIL ovr_data got %h exp 34", RX_DATA); end
      tests++; if ({RXRDY, OVF} !== 2'b11) begin fails++; $display("FAIL ovr_flags got %b exp 11", {RXRDY, OVF}); end
      pulse_clr;
      tests++; if ({RXRDY, OVF} !== 2'b00) begin fails++; $display("FAIL ovr_clr got %b exp 00", {RXRDY, OVF}); end
      send(9'h056, 8, 8, 1'b1, -1, -1, lat);
      send(9'h078, 8, 8, 1'b1, 76, -1, lat);
      tests++; if (RX_DATA !== 8'h78) begin fails++; $display("FAIL clr_done_data got %h exp 78", RX_DATA); end
      tests++; if ({RXRDY, OVF} !== 2'b10) begin fails++; $display("FAIL clr_done_flags got %b exp 10", {RXRDY, OVF}); end
   endtask

   task automatic test_reset_mid;
      RX = 0;
      repeat (8) @(negedge CLK);
      RX = 1;
      repeat (10) @(negedge CLK);
      RESET = 1;
      @(negedge CLK);
      tests++; if (RX_DATA !== 8'h00) begin fails++; $display("FAIL mid_reset_data got %h exp 00", RX_DATA); end
      tests++; if ({RXRDY, PERR, FERR, OVF} !== 4'b0000) begin fails++; $display("FAIL mid_reset_flags got %b exp 0000", {RXRDY, PERR, FERR, OVF}); end
      RESET = 0;
      repeat (16) @(negedge CLK);
      send(9'h081, 8, 8, 1'b1, -1, -1, lat);
      tests++; if (lat !== 77) begin fails++; $display("FAIL post_reset_lat got %0d exp 77", lat); end
      tests++; if (RX_DATA !== 8'h81) begin fails++; $display("FAIL post_reset_data got %h exp 81", RX_DATA); end
      pulse_clr;
      EIGHT = 0;
      send(9'h02B, 7, 8, 1'b1, -1, 20, lat);
      tests++; if (lat !== 69) begin fails++; $display("FAIL toggle_lat got %0d exp 69", lat); end
      tests++; if (RX_DATA !== 8'h2B) begin fails++; $display("FAIL toggle_data got %h exp 2b", RX_DATA); end
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_7e;
      test_odd_ferr;
      test_glitch;
      test_overrun;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
